// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard sequencer: load-use stalls, flag-dependent branch wait,
// branch resolution from the registered CCR and a saturating stall counter.
module ex_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic             id_is_branch,
  input  logic [1:0]       id_branch_cond,
  input  logic [2:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_sets_ccr,
  input  logic [2:0]       ccr_r,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             branch_taken,
  output logic [2:0]       ccr_clear,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned LU_W = 3;
  localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LU_STALL_CYCLES - 1);
  localparam logic [1:0] COND_JZ  = 2'b00;
  localparam logic [1:0] COND_JN  = 2'b01;
  localparam logic [1:0] COND_JC  = 2'b10;
  localparam logic [1:0] COND_JMP = 2'b11;

  typedef enum logic [1:0] {RUN, LU_STALL, CC_WAIT} state_t;

  state_t           state_q, state_nxt;
  logic [LU_W-1:0]  lu_cnt_q, lu_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             lu_hazard, cc_hazard, cond_true;
  logic [2:0]       clr_onehot;
  logic             hold, taken;
  logic [2:0]       clr;

  // Hazard detection against the instruction currently in EX
  assign lu_hazard = ex_memread & ex_regwrite &
                     ((id_src1_used & (id_src1 == ex_rd)) |
                      (id_src2_used & (id_src2 == ex_rd)));
  assign cc_hazard = id_is_branch & (id_branch_cond != COND_JMP) & ex_sets_ccr;

  // Condition evaluation and the flag consumed by a taken conditional jump
  always_comb begin
    cond_true  = 1'b1;
    clr_onehot = 3'b000;
    case (id_branch_cond)
      COND_JZ: begin cond_true = ccr_r[0]; clr_onehot = 3'b001; end
      COND_JN: begin cond_true = ccr_r[1]; clr_onehot = 3'b010; end
      COND_JC: begin cond_true = ccr_r[2]; clr_onehot = 3'b100; end
      default: begin cond_true = 1'b1;     clr_onehot = 3'b000; end
    endcase
  end

  always_comb begin
    state_nxt  = state_q;
    lu_cnt_nxt = lu_cnt_q;
    hold       = 1'b0;
    taken      = 1'b0;
    clr        = 3'b000;
    case (state_q)
      RUN: begin
        if (lu_hazard) begin
          hold = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            lu_cnt_nxt = LU_RELOAD;
            state_nxt  = LU_STALL;
          end
        end else if (cc_hazard) begin
          hold      = 1'b1;
          state_nxt = CC_WAIT;
        end else if (id_is_branch && cond_true) begin
          taken = 1'b1;
          clr   = clr_onehot;
        end
      end
      LU_STALL: begin
        hold       = 1'b1;
        lu_cnt_nxt = lu_cnt_q - LU_W'(1);
        if (lu_cnt_q == LU_W'(1)) state_nxt = RUN;
      end
      CC_WAIT: begin
        // EX now holds a bubble, so ccr_r reflects the flag-setting instruction
        if (id_is_branch && cond_true) begin
          taken = 1'b1;
          clr   = clr_onehot;
        end
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      state_nxt  = RUN;
      lu_cnt_nxt = '0;
      hold       = 1'b0;
      taken      = 1'b0;
      clr        = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      lu_cnt_q <= lu_cnt_nxt;
      if (hold && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign pc_hold      = hold;
  assign ifid_hold    = hold;
  assign idex_bubble  = hold;
  assign flush_ifid   = taken;
  assign branch_taken = taken;
  assign ccr_clear    = clr;
  assign stall_count  = reset ? stall_cnt_q : '0;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: three instances (1-cycle stall, 3-cycle
// stall, 4-bit counter) share one stimulus stream; each test resets first.
module tb_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] id_src1, id_src2, ex_rd, ccr_r;
  logic id_src1_used, id_src2_used, id_is_branch, ex_regwrite, ex_memread, ex_sets_ccr;
  logic [1:0] id_branch_cond;

  logic a_pc_hold, a_ifid_hold, a_idex_bubble, a_flush_ifid, a_branch_taken;
  logic b_pc_hold, b_ifid_hold, b_idex_bubble, b_flush_ifid, b_branch_taken;
  logic c_pc_hold, c_ifid_hold, c_idex_bubble, c_flush_ifid, c_branch_taken;
  logic [2:0] a_ccr_clear, b_ccr_clear, c_ccr_clear;
  logic [15:0] a_stall_count, b_stall_count;
  logic [3:0] c_stall_count;

  int errors = 0;
  int checks = 0;
  logic running = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_is_branch(id_is_branch), .id_branch_cond(id_branch_cond),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_sets_ccr(ex_sets_ccr), .ccr_r(ccr_r),
    .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_bubble(a_idex_bubble),
    .flush_ifid(a_flush_ifid), .branch_taken(a_branch_taken),
    .ccr_clear(a_ccr_clear), .stall_count(a_stall_count));

  ex_hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_is_branch(id_is_branch), .id_branch_cond(id_branch_cond),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_sets_ccr(ex_sets_ccr), .ccr_r(ccr_r),
    .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .idex_bubble(b_idex_bubble),
    .flush_ifid(b_flush_ifid), .branch_taken(b_branch_taken),
    .ccr_clear(b_ccr_clear), .stall_count(b_stall_count));

  ex_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_is_branch(id_is_branch), .id_branch_cond(id_branch_cond),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_sets_ccr(ex_sets_ccr), .ccr_r(ccr_r),
    .pc_hold(c_pc_hold), .ifid_hold(c_ifid_hold), .idex_bubble(c_idex_bubble),
    .flush_ifid(c_flush_ifid), .branch_taken(c_branch_taken),
    .ccr_clear(c_ccr_clear), .stall_count(c_stall_count));

  // Output invariants on every cycle: holds move together, no hold with a taken branch
  always @(negedge clk) begin
    if (running) begin
      checks++;
      if ((a_pc_hold & a_branch_taken) | (b_pc_hold & b_branch_taken) | (c_pc_hold & c_branch_taken)) begin
        errors++; $display("FAIL inv_hold_vs_taken a=%b%b b=%b%b c=%b%b exp=no_overlap",
          a_pc_hold, a_branch_taken, b_pc_hold, b_branch_taken, c_pc_hold, c_branch_taken);
      end
      checks++;
      if ({a_ifid_hold, a_idex_bubble, b_ifid_hold, b_idex_bubble, c_ifid_hold, c_idex_bubble} !==
          {a_pc_hold, a_pc_hold, b_pc_hold, b_pc_hold, c_pc_hold, c_pc_hold}) begin
        errors++; $display("FAIL inv_holds got=%b%b%b%b%b%b exp=%b%b%b%b%b%b",
          a_ifid_hold, a_idex_bubble, b_ifid_hold, b_idex_bubble, c_ifid_hold, c_idex_bubble,
          a_pc_hold, a_pc_hold, b_pc_hold, b_pc_hold, c_pc_hold, c_pc_hold);
      end
      checks++;
      if ({a_flush_ifid, b_flush_ifid, c_flush_ifid} !== {a_branch_taken, b_branch_taken, c_branch_taken} ||
          (!c_branch_taken && c_ccr_clear !== 3'b000) || (!b_branch_taken && b_ccr_clear !== 3'b000)) begin
        errors++; $display("FAIL inv_flush got=%b%b%b clr_b=%b clr_c=%b exp=flush_eq_taken",
          a_flush_ifid, b_flush_ifid, c_flush_ifid, b_ccr_clear, c_ccr_clear);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1 = 3'd0; id_src2 = 3'd0; id_src1_used = 1'b0; id_src2_used = 1'b0;
    id_is_branch = 1'b0; id_branch_cond = 2'b00; ex_rd = 3'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_sets_ccr = 1'b0; ccr_r = 3'b000;
  endtask

  task automatic clear_ex();
    ex_rd = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_sets_ccr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic load_r3_src1();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd3;
    id_src1 = 3'd3; id_src1_used = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    load_r3_src1();
    id_is_branch = 1'b1; id_branch_cond = 2'b11;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_ccr_clear, b_pc_hold, b_branch_taken} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got=%b%b%b%b%b exp=0", a_pc_hold, a_branch_taken, a_ccr_clear, b_pc_hold, b_branch_taken);
    end
    tick();
    checks++;
    if (a_stall_count !== 16'd0 || b_stall_count !== 16'd0 || c_stall_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got=%0d/%0d/%0d exp=0", a_stall_count, b_stall_count, c_stall_count);
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_lu1();
    do_reset();
    load_r3_src1();
    #1;
    checks++;
    if (a_pc_hold !== 1'b1) begin errors++; $display("FAIL lu1_hold got=%b exp=1", a_pc_hold); end
    tick();
    clear_ex();
    #1;
    checks++;
    if (a_pc_hold !== 1'b0) begin errors++; $display("FAIL lu1_release got=%b exp=0", a_pc_hold); end
    checks++;
    if (a_stall_count !== 16'd1) begin errors++; $display("FAIL lu1_count got=%0d exp=1", a_stall_count); end
  endtask

  task automatic test_lu3();
    do_reset();
    load_r3_src1();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b_pc_hold !== 1'b1) begin errors++; $display("FAIL lu3_hold_%0d got=%b exp=1", i, b_pc_hold); end
      tick();
      clear_ex();
    end
    #1;
    checks++;
    if (b_pc_hold !== 1'b0) begin errors++; $display("FAIL lu3_release got=%b exp=0", b_pc_hold); end
    checks++;
    if (b_stall_count !== 16'd3) begin errors++; $display("FAIL lu3_count got=%0d exp=3", b_stall_count); end
    clear_inputs();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd3; id_src2 = 3'd3; id_src2_used = 1'b0;
    #1;
    checks++;
    if (b_pc_hold !== 1'b0) begin errors++; $display("FAIL lu_src2_unused got=%b exp=0", b_pc_hold); end
    id_src2_used = 1'b1;
    #1;
    checks++;
    if (b_pc_hold !== 1'b1) begin errors++; $display("FAIL lu_src2_used got=%b exp=1", b_pc_hold); end
    clear_inputs();
  endtask

  task automatic test_cc_wait();
    do_reset();
    id_is_branch = 1'b1; id_branch_cond = 2'b00; ex_sets_ccr = 1'b1; ccr_r = 3'b000;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken} !== 2'b10) begin errors++; $display("FAIL jz_wait got=%b%b exp=10", a_pc_hold, a_branch_taken); end
    tick();
    ccr_r = 3'b001;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_flush_ifid, a_ccr_clear} !== 6'b011001) begin
      errors++; $display("FAIL jz_taken got=%b%b%b%b exp=011001", a_pc_hold, a_branch_taken, a_flush_ifid, a_ccr_clear);
    end
    tick();
    ccr_r = 3'b000;
    #1;
    checks++;
    if (a_pc_hold !== 1'b1) begin errors++; $display("FAIL jz2_wait got=%b exp=1", a_pc_hold); end
    tick();
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_flush_ifid, a_ccr_clear} !== 6'b0) begin
      errors++; $display("FAIL jz_not_taken got=%b%b%b%b exp=000000", a_pc_hold, a_branch_taken, a_flush_ifid, a_ccr_clear);
    end
    clear_inputs();
  endtask

  task automatic test_immediate();
    do_reset();
    id_is_branch = 1'b1; id_branch_cond = 2'b10; ex_sets_ccr = 1'b0; ccr_r = 3'b100;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_ccr_clear} !== 5'b01100) begin
      errors++; $display("FAIL jc_taken got=%b%b%b exp=01100", a_pc_hold, a_branch_taken, a_ccr_clear);
    end
    tick();
    id_branch_cond = 2'b11; ex_sets_ccr = 1'b1; ccr_r = 3'b000;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_ccr_clear} !== 5'b01000) begin
      errors++; $display("FAIL jmp_taken got=%b%b%b exp=01000", a_pc_hold, a_branch_taken, a_ccr_clear);
    end
    tick();
    id_branch_cond = 2'b01; ex_sets_ccr = 1'b0; ccr_r = 3'b101;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_ccr_clear} !== 5'b0) begin
      errors++; $display("FAIL jn_not_taken got=%b%b%b exp=00000", a_pc_hold, a_branch_taken, a_ccr_clear);
    end
    tick();
    id_branch_cond = 2'b00; ccr_r = 3'b001;
    #1;
    checks++;
    if ({a_branch_taken, a_ccr_clear} !== 4'b1001) begin
      errors++; $display("FAIL jz_after_jmp got=%b%b exp=1001", a_branch_taken, a_ccr_clear);
    end
    clear_inputs();
  endtask

  task automatic test_lu_priority();
    do_reset();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd5; id_src2 = 3'd5; id_src2_used = 1'b1;
    id_is_branch = 1'b1; id_branch_cond = 2'b01; ccr_r = 3'b010;
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken} !== 2'b10) begin errors++; $display("FAIL prio_stall got=%b%b exp=10", a_pc_hold, a_branch_taken); end
    tick();
    clear_ex();
    #1;
    checks++;
    if ({a_pc_hold, a_branch_taken, a_ccr_clear} !== 5'b01010) begin
      errors++; $display("FAIL prio_branch got=%b%b%b exp=01010", a_pc_hold, a_branch_taken, a_ccr_clear);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    load_r3_src1();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (c_stall_count !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", c_stall_count); end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (c_stall_count !== 4'd15) begin errors++; $display("FAIL sat_end got=%0d exp=15", c_stall_count); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    load_r3_src1();
    tick();
    clear_inputs();
    #1;
    checks++;
    if (b_pc_hold !== 1'b1) begin errors++; $display("FAIL mid_stall_hold got=%b exp=1", b_pc_hold); end
    reset = 1'b0;
    #1;
    checks++;
    if ({b_pc_hold, b_stall_count} !== 17'd0) begin errors++; $display("FAIL mid_reset_low got=%b/%0d exp=0/0", b_pc_hold, b_stall_count); end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({b_pc_hold, b_stall_count} !== 17'd0) begin errors++; $display("FAIL mid_reset_run got=%b/%0d exp=0/0", b_pc_hold, b_stall_count); end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    tick();
    running = 1'b1;
    test_reset();
    test_lu1();
    test_lu3();
    test_cc_wait();
    test_immediate();
    test_lu_priority();
    test_saturation();
    test_reset_mid_stall();
    running = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
